// File: rtl/lbist_controller.sv
// lbist_controller: sequences one logic-BIST session (LFSR seed, shift/capture
// windows, MISR unload, signature compare) and reports pass/fail on go_nogo_o.
module lbist_controller #(
  parameter int                   CHAIN_LEN    = 64,
  parameter int                   NUM_PATTERNS = 1024,
  parameter int                   SIG_WIDTH    = 32,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 32'h5A3C_96E1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 normal_test_i,
  input  logic [SIG_WIDTH-1:0] misr_sig_i,
  output logic                 test_mode_o,
  output logic                 scan_en_o,
  output logic                 lfsr_load_o,
  output logic                 lfsr_en_o,
  output logic                 misr_clr_o,
  output logic                 misr_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 go_nogo_o
);

  localparam int SW = $clog2(CHAIN_LEN);
  localparam int PW = $clog2(NUM_PATTERNS + 1);

  localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST   = PW'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    COMPARE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_shift_cnt;
  logic [SW-1:0] w_shift_cnt_nxt;
  logic [PW-1:0] r_pat_cnt;
  logic [PW-1:0] w_pat_cnt_nxt;
  logic          r_go_nogo;
  logic          w_go_nogo_nxt;

  // State, counters and result register; reset aborts any session at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift_cnt <= '0;
      r_pat_cnt   <= '0;
      r_go_nogo   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift_cnt <= w_shift_cnt_nxt;
      r_pat_cnt   <= w_pat_cnt_nxt;
      r_go_nogo   <= w_go_nogo_nxt;
    end
  end

  // Next-state/counter logic plus output decode; outputs depend on state and
  // counters only, so no input reaches an output combinationally.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_cnt_nxt = r_shift_cnt;
    w_pat_cnt_nxt   = r_pat_cnt;
    w_go_nogo_nxt   = r_go_nogo;
    test_mode_o     = 1'b0;
    scan_en_o       = 1'b0;
    lfsr_load_o     = 1'b0;
    lfsr_en_o       = 1'b0;
    misr_clr_o      = 1'b0;
    misr_en_o       = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;

    case (r_state)
      IDLE: begin
        if (!normal_test_i) begin
          w_state_nxt   = INIT;
          w_go_nogo_nxt = 1'b0;
        end
      end
      INIT: begin
        test_mode_o     = 1'b1;
        lfsr_load_o     = 1'b1;
        misr_clr_o      = 1'b1;
        busy_o          = 1'b1;
        w_shift_cnt_nxt = '0;
        w_pat_cnt_nxt   = '0;
        w_state_nxt     = SHIFT;
      end
      SHIFT: begin
        test_mode_o = 1'b1;
        scan_en_o   = 1'b1;
        lfsr_en_o   = 1'b1;
        busy_o      = 1'b1;
        // The very first load shifts out uncaptured flops, not a response.
        misr_en_o   = (r_pat_cnt != '0);
        if (r_shift_cnt == SHIFT_LAST) begin
          w_shift_cnt_nxt = '0;
          w_state_nxt     = CAPTURE;
        end else begin
          w_shift_cnt_nxt = r_shift_cnt + SW'(1);
        end
      end
      CAPTURE: begin
        test_mode_o   = 1'b1;
        busy_o        = 1'b1;
        w_pat_cnt_nxt = r_pat_cnt + PW'(1);
        w_state_nxt   = (r_pat_cnt == PAT_LAST) ? UNLOAD : SHIFT;
      end
      UNLOAD: begin
        test_mode_o = 1'b1;
        scan_en_o   = 1'b1;
        misr_en_o   = 1'b1;
        busy_o      = 1'b1;
        if (r_shift_cnt == SHIFT_LAST) begin
          w_shift_cnt_nxt = '0;
          w_state_nxt     = COMPARE;
        end else begin
          w_shift_cnt_nxt = r_shift_cnt + SW'(1);
        end
      end
      COMPARE: begin
        test_mode_o   = 1'b1;
        busy_o        = 1'b1;
        w_go_nogo_nxt = (misr_sig_i == GOLDEN_SIG);
        w_state_nxt   = DONE;
      end
      DONE: begin
        test_mode_o = 1'b1;
        done_o      = 1'b1;
        if (normal_test_i) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Returning to functional mode mid-session abandons it with no result.
    if (busy_o && normal_test_i) begin
      w_state_nxt     = IDLE;
      w_shift_cnt_nxt = '0;
      w_pat_cnt_nxt   = '0;
      w_go_nogo_nxt   = 1'b0;
    end
  end

  assign go_nogo_o = r_go_nogo;

endmodule
